toggle_merge_mealy: RTL and testbench

- Synchronous Mealy FSM implementing the inverse of the toggle: collects two alternating 4-phase event streams (Ri1, Ri2) and merges them into one output event stream (Ro).
- Required event order: Ri1+ -> Ro+, Ri2+ -> Ro-, Ri1- -> Ro+, Ri2- -> Ro-, then repeat.
- Sits on the receiving side of a toggle's two outputs: recombines the Ro1/Ro2 split back into a single channel, in the same event-pulse (PLUS/MINUS) signalling style.

---
 rtl/toggle_merge_mealy.sv | 168 ++++++++++++++++
 tb/tb_toggle_merge_mealy.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_merge_mealy.sv
// -----------------------------------------------------------------------------
// toggle_merge_mealy
//
// Purpose:
//   Receiving-side counterpart of a toggle. Two alternating 4-phase event
//   streams (channel 1 and channel 2) are merged into one output event stream.
//   The accepted order is Ri1+ -> Ri2+ -> Ri1- -> Ri2-, and the output
//   alternates Ro+, Ro-, Ro+, Ro-. Each input event that arrives before its
//   turn is held in a one-bit pending slot. It fires as soon as the FSM
//   expects it.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      synchronous active-low reset (0 = reset)
//   Ri1_PLUS   single-cycle pulse, rising event on channel 1
//   Ri1_MINUS  single-cycle pulse, falling event on channel 1
//   Ri2_PLUS   single-cycle pulse, rising event on channel 2
//   Ri2_MINUS  single-cycle pulse, falling event on channel 2
//   Ro_PLUS    Mealy pulse, merged rising event (zero latency)
//   Ro_MINUS   Mealy pulse, merged falling event (zero latency)
//   Ro_level   registered level of the merged signal
//   cycles     completed 4-event cycles, wraps modulo 2^CNT_W
//   err        sticky protocol-violation flag (tied 0 without the macro)
//   err_cnt    dropped-event count, saturates at 255 (macro builds only)
//
// Optional feature macro: TOGGLE_MERGE_ERR_EN
//   Defined   : err is a sticky violation flag and the err_cnt port is present.
//   Undefined : err is tied to 0 and err_cnt does not exist. Duplicate events
//               are still dropped.
//
// States:
//   S0 | waiting for Ri1+, fires Ro+
//   S1 | waiting for Ri2+, fires Ro-
//   S2 | waiting for Ri1-, fires Ro+
//   S3 | waiting for Ri2-, fires Ro- and completes a cycle
// -----------------------------------------------------------------------------
module toggle_merge_mealy #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ri1_PLUS,
    input  logic             Ri1_MINUS,
    input  logic             Ri2_PLUS,
    input  logic             Ri2_MINUS,
    output logic             Ro_PLUS,
    output logic             Ro_MINUS,
    output logic             Ro_level,
    output logic [CNT_W-1:0] cycles,
    output logic             err
`ifdef TOGGLE_MERGE_ERR_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_pend;        // {2m, 1m, 2p, 1p}
    logic [3:0]         w_pend_next;
    logic [3:0]         w_in;
    logic [3:0]         w_eff;
    logic [1:0]         w_idx;
    logic               w_fire;
    logic               w_plus;
    logic               w_minus;
    logic               r_level;
    logic [CNT_W-1:0]   r_cycles;

    // The event bits are ordered so that a state's encoding is also the index
    // of the event that state expects.
    assign w_in  = {Ri2_MINUS, Ri1_MINUS, Ri2_PLUS, Ri1_PLUS};
    assign w_eff = w_in | r_pend;
    assign w_idx = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_plus       = 1'b0;
        w_minus      = 1'b0;
        w_fire       = w_eff[w_idx];
        // An event that is already pending is not stored a second time. That
        // duplicate is dropped, including when it is the event firing now.
        w_pend_next  = r_pend | (w_in & ~r_pend);
        if (w_fire) begin
            w_pend_next[w_idx] = 1'b0;
            case (r_state)
                S0: begin w_next_state = S1; w_plus  = 1'b1; end
                S1: begin w_next_state = S2; w_minus = 1'b1; end
                S2: begin w_next_state = S3; w_plus  = 1'b1; end
                S3: begin w_next_state = S0; w_minus = 1'b1; end
                default: w_next_state = S0;
            endcase
        end
        // No output pulse is allowed in a reset cycle, whatever the inputs.
        Ro_PLUS  = w_plus  & reset;
        Ro_MINUS = w_minus & reset;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend   <= '0;
            r_level  <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_plus) begin
                r_level <= 1'b1;
            end else if (w_minus) begin
                r_level <= 1'b0;
            end
            if (w_fire && r_state == S3) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
        end
    end

    assign Ro_level = r_level;
    assign cycles   = r_cycles;

`ifdef TOGGLE_MERGE_ERR_EN
    logic [3:0] w_dup;
    logic [2:0] w_dup_n;
    logic [8:0] w_cnt_sum;
    logic       r_err;
    logic [7:0] r_err_cnt;

    // Several channels can be duplicated in the same cycle. Each dropped event
    // is counted.
    always_comb begin
        w_dup     = w_in & r_pend;
        w_dup_n   = 3'(w_dup[0]) + 3'(w_dup[1]) + 3'(w_dup[2]) + 3'(w_dup[3]);
        w_cnt_sum = {1'b0, r_err_cnt} + 9'(w_dup_n);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (|w_dup) begin
                r_err <= 1'b1;
            end
            r_err_cnt <= (w_cnt_sum > 9'd255) ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_merge_mealy.sv
module tb_toggle_merge_mealy;

    localparam int CNT_W = 2;
`ifdef TOGGLE_MERGE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             Ri1_PLUS = 1'b0, Ri1_MINUS = 1'b0, Ri2_PLUS = 1'b0, Ri2_MINUS = 1'b0;
    logic             Ro_PLUS, Ro_MINUS, Ro_level, err;
    logic [CNT_W-1:0] cycles;
`ifdef TOGGLE_MERGE_ERR_EN
    logic [7:0]       err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic s_plus, s_minus, s_level, s_err;
    logic [CNT_W-1:0] s_cycles;
    logic [7:0] s_err_cnt;

    toggle_merge_mealy #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Ri1_PLUS  (Ri1_PLUS),
        .Ri1_MINUS (Ri1_MINUS),
        .Ri2_PLUS  (Ri2_PLUS),
        .Ri2_MINUS (Ri2_MINUS),
        .Ro_PLUS   (Ro_PLUS),
        .Ro_MINUS  (Ro_MINUS),
        .Ro_level  (Ro_level),
        .cycles    (cycles),
        .err       (err)
`ifdef TOGGLE_MERGE_ERR_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One clock cycle. The inputs are applied at the falling edge. The Mealy
    // outputs are sampled in that cycle, and the registered outputs just
    // after the following rising edge.
    // v = {Ri2-, Ri1-, Ri2+, Ri1+}
    task automatic cyc(input logic [3:0] v, input logic rst_n);
        @(negedge clk);
        {Ri2_MINUS, Ri1_MINUS, Ri2_PLUS, Ri1_PLUS} = v;
        reset = rst_n;
        #1;
        s_plus  = Ro_PLUS;
        s_minus = Ro_MINUS;
        @(posedge clk);
        #1;
        s_level  = Ro_level;
        s_cycles = cycles;
        s_err    = err;
`ifdef TOGGLE_MERGE_ERR_EN
        s_err_cnt = err_cnt;
`else
        s_err_cnt = 8'd0;
`endif
        {Ri2_MINUS, Ri1_MINUS, Ri2_PLUS, Ri1_PLUS} = 4'b0000;
    endtask

    task automatic test_reset();
        cyc(4'b0001, 1'b0);
        n_checks++;
        if ({s_plus, s_minus} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_pulse: got p/m=%b want 00", {s_plus, s_minus});
        end
        cyc(4'b0000, 1'b0);
        n_checks++;
        if ({s_level, s_cycles, s_err, s_err_cnt} !== {1'b0, 2'd0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL reset_state: got lvl=%b cyc=%0d err=%b ecnt=%0d want 0 0 0 0",
                     s_level, s_cycles, s_err, s_err_cnt);
        end
    endtask

    task automatic test_in_order();
        logic [3:0] vin [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                4'b0100, 4'b0000, 4'b1000, 4'b0000};
        logic [2:0] exp [8] = '{3'b101, 3'b001, 3'b010, 3'b000,
                                3'b101, 3'b001, 3'b010, 3'b000};
        for (int i = 0; i < 8; i++) begin
            cyc(vin[i], 1'b1);
            n_checks++;
            if ({s_plus, s_minus, s_level} !== exp[i]) begin
                n_errors++;
                $display("FAIL in_order step %0d: got p/m/lvl=%b want %b", i, {s_plus, s_minus, s_level}, exp[i]);
            end
        end
        n_checks++;
        if ({s_cycles, s_err} !== {2'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL in_order_cnt: got cyc=%0d err=%b want 1 0", s_cycles, s_err);
        end
    endtask

    task automatic test_early();
        logic [3:0] vin [6] = '{4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b1000};
        logic [2:0] exp [6] = '{3'b000, 3'b000, 3'b101, 3'b010, 3'b101, 3'b010};
        for (int i = 0; i < 6; i++) begin
            cyc(vin[i], 1'b1);
            n_checks++;
            if ({s_plus, s_minus, s_level} !== exp[i]) begin
                n_errors++;
                $display("FAIL early step %0d: got p/m/lvl=%b want %b", i, {s_plus, s_minus, s_level}, exp[i]);
            end
        end
        n_checks++;
        if (s_cycles !== 2'd2) begin
            n_errors++;
            $display("FAIL early_cnt: got cyc=%0d want 2", s_cycles);
        end
    endtask

    task automatic test_duplicate();
        logic [3:0] vin [8] = '{4'b0010, 4'b0010, 4'b0000, 4'b0001,
                                4'b0000, 4'b0000, 4'b0100, 4'b1000};
        logic [2:0] exp [8] = '{3'b000, 3'b000, 3'b000, 3'b101,
                                3'b010, 3'b000, 3'b101, 3'b010};
        for (int i = 0; i < 8; i++) begin
            cyc(vin[i], 1'b1);
            n_checks++;
            if ({s_plus, s_minus, s_level} !== exp[i]) begin
                n_errors++;
                $display("FAIL dup step %0d: got p/m/lvl=%b want %b", i, {s_plus, s_minus, s_level}, exp[i]);
            end
            if (i == 1) begin
                n_checks++;
                if ({s_err, s_err_cnt} !== {ERR_EN, 8'(ERR_EN)}) begin
                    n_errors++;
                    $display("FAIL dup_err: got err=%b ecnt=%0d want %b %0d", s_err, s_err_cnt, ERR_EN, ERR_EN);
                end
            end
        end
        n_checks++;
        if (s_cycles !== 2'd3) begin
            n_errors++;
            $display("FAIL dup_cnt: got cyc=%0d want 3", s_cycles);
        end
    endtask

    // Completes the fourth full cycle, so the 2-bit counter wraps to 0.
    task automatic test_simultaneous();
        logic [3:0] vin [4] = '{4'b0011, 4'b0000, 4'b0100, 4'b1000};
        logic [2:0] exp [4] = '{3'b101, 3'b010, 3'b101, 3'b010};
        for (int i = 0; i < 4; i++) begin
            cyc(vin[i], 1'b1);
            n_checks++;
            if ({s_plus, s_minus, s_level} !== exp[i]) begin
                n_errors++;
                $display("FAIL simul step %0d: got p/m/lvl=%b want %b", i, {s_plus, s_minus, s_level}, exp[i]);
            end
        end
        n_checks++;
        if ({s_cycles, s_err, s_err_cnt} !== {2'd0, ERR_EN, 8'(ERR_EN)}) begin
            n_errors++;
            $display("FAIL simul_wrap: got cyc=%0d err=%b ecnt=%0d want 0 %b %0d",
                     s_cycles, s_err, s_err_cnt, ERR_EN, ERR_EN);
        end
    endtask

    // The expected event arrives while its pending copy fires. The new copy
    // must be dropped and must not fire again one cycle later.
    task automatic test_back_to_back();
        logic [3:0] vin [10] = '{4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b1000};
        logic [2:0] exp [10] = '{3'b000, 3'b101, 3'b010, 3'b101, 3'b010,
                                 3'b101, 3'b001, 3'b010, 3'b101, 3'b010};
        for (int i = 0; i < 10; i++) begin
            cyc(vin[i], 1'b1);
            n_checks++;
            if ({s_plus, s_minus, s_level} !== exp[i]) begin
                n_errors++;
                $display("FAIL b2b step %0d: got p/m/lvl=%b want %b", i, {s_plus, s_minus, s_level}, exp[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (s_err_cnt !== (ERR_EN ? 8'd2 : 8'd0)) begin
                    n_errors++;
                    $display("FAIL b2b_ecnt: got %0d want %0d", s_err_cnt, ERR_EN ? 2 : 0);
                end
            end
        end
        n_checks++;
        if (s_cycles !== 2'd2) begin
            n_errors++;
            $display("FAIL b2b_cnt: got cyc=%0d want 2", s_cycles);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] pre [3] = '{4'b0001, 4'b1000, 4'b0010};
        logic [2:0] pex [3] = '{3'b101, 3'b001, 3'b010};
        logic [3:0] vin [6] = '{4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
        logic [2:0] exp [6] = '{3'b000, 3'b000, 3'b101, 3'b010, 3'b101, 3'b010};
        for (int i = 0; i < 3; i++) begin
            cyc(pre[i], 1'b1);
            n_checks++;
            if ({s_plus, s_minus, s_level} !== pex[i]) begin
                n_errors++;
                $display("FAIL rstmid_pre step %0d: got p/m/lvl=%b want %b", i, {s_plus, s_minus, s_level}, pex[i]);
            end
        end
        cyc(4'b0100, 1'b0);
        n_checks++;
        if ({s_plus, s_minus} !== 2'b00) begin
            n_errors++;
            $display("FAIL rstmid_pulse: got p/m=%b want 00", {s_plus, s_minus});
        end
        n_checks++;
        if ({s_level, s_cycles, s_err, s_err_cnt} !== {1'b0, 2'd0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL rstmid_state: got lvl=%b cyc=%0d err=%b ecnt=%0d want 0 0 0 0",
                     s_level, s_cycles, s_err, s_err_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(vin[i], 1'b1);
            n_checks++;
            if ({s_plus, s_minus, s_level} !== exp[i]) begin
                n_errors++;
                $display("FAIL rstmid step %0d: got p/m/lvl=%b want %b", i, {s_plus, s_minus, s_level}, exp[i]);
            end
        end
        n_checks++;
        if (s_cycles !== 2'd1) begin
            n_errors++;
            $display("FAIL rstmid_cnt: got cyc=%0d want 1", s_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_early();
        test_duplicate();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
